// File: rtl/bit_unshifter_if.sv
// rtl/bit_unshifter_if.sv - input/output handshake bundle for the bit unshifter
interface bit_unshifter_if #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_val;
  logic [CNT_W-1:0] in_divider;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [CNT_W-1:0] out_divider;
  logic             out_sat;
  logic             busy;

  modport slave (
    input  in_valid, in_val, in_divider, out_ready,
    output in_ready, out_valid, out_val, out_divider, out_sat, busy
  );

  modport master (
    output in_valid, in_val, in_divider, out_ready,
    input  in_ready, out_valid, out_val, out_divider, out_sat, busy
  );
endinterface

// File: rtl/bit_unshifter.sv
// rtl/bit_unshifter.sv - restores a left-normalized value by one STEP-bit right shift per clock
module bit_unshifter #(
  parameter int WIDTH = 40,
  parameter int STEP  = 4,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  bit_unshifter_if.slave  bus
);
  localparam int               MAX_SHIFTS = WIDTH / STEP;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_SHIFTS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_out_divider;
  logic             r_out_sat;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_sat;
  logic [CNT_W-1:0] w_count_dec;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_sat       = (bus.in_divider > MAX_CNT);
  assign w_count_dec = r_count - 1'b1;

  // Saturated requests still run MAX_CNT shifts, which empties data_reg to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_data        <= '0;
      r_count       <= '0;
      r_out_divider <= '0;
      r_out_sat     <= 1'b0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data        <= bus.in_val;
            r_out_divider <= bus.in_divider;
            r_out_sat     <= w_sat;
            r_count       <= w_sat ? MAX_CNT : bus.in_divider;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b1;
            if (bus.in_divider == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_data  <= r_data >> STEP;
          r_count <= w_count_dec;
          if (w_count_dec == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_val     = r_data;
  assign bus.out_divider = r_out_divider;
  assign bus.out_sat     = r_out_sat;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_bit_unshifter.sv
// tb/tb_bit_unshifter.sv - randomized and directed self-checking bench for bit_unshifter
module tb_bit_unshifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bit_unshifter_if #(.WIDTH(40), .CNT_W(4)) bus ();

  bit_unshifter #(.WIDTH(40), .STEP(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: divider beyond 10 nibbles clears everything, otherwise a plain nibble shift.
  function automatic logic [39:0] model_val(input logic [39:0] v, input int d);
    if (d > 10) return 40'd0;
    return v >> (4 * d);
  endfunction

  function automatic int model_lat(input int d);
    return ((d > 10) ? 10 : d) + 1;
  endfunction

  task automatic do_txn(input logic [39:0] v, input logic [3:0] d, input int hold,
                        output logic [39:0] gv, output logic [3:0] gd, output logic gs,
                        output int lat, output int errs);
    int guard;
    errs = 0;
    @(negedge clk);
    bus.in_val = v; bus.in_divider = d; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) errs++;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
    gv = bus.out_val; gd = bus.out_divider; gs = bus.out_sat;
    repeat (hold) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_val !== gv || bus.out_divider !== gd ||
          bus.out_sat !== gs || bus.in_ready !== 1'b0) errs++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) errs++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++; if (bus.out_val !== 40'd0) begin n_fail++; $display("FAIL reset_out_val got=%h exp=0", bus.out_val); end
    n_tests++; if (bus.out_divider !== 4'd0) begin n_fail++; $display("FAIL reset_out_divider got=%0d exp=0", bus.out_divider); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic_shift();
    logic [39:0] gv; logic [3:0] gd; logic gs; int lat, errs;
    do_txn(40'he2b9946000, 4'd3, 0, gv, gd, gs, lat, errs);
    n_tests++; if (gv !== 40'h000e2b9946) begin n_fail++; $display("FAIL basic_val got=%h exp=000e2b9946", gv); end
    n_tests++; if (gd !== 4'd3) begin n_fail++; $display("FAIL basic_div got=%0d exp=3", gd); end
    n_tests++; if (gs !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b exp=0", gs); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL basic_handshake errors got=%0d exp=0", errs); end
  endtask

  task automatic test_zero_div();
    logic [39:0] gv; logic [3:0] gd; logic gs; int lat, errs;
    do_txn(40'h011e2b9946, 4'd0, 0, gv, gd, gs, lat, errs);
    n_tests++; if (gv !== 40'h011e2b9946) begin n_fail++; $display("FAIL zero_val got=%h exp=011e2b9946", gv); end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL zero_handshake errors got=%0d exp=0", errs); end
  endtask

  task automatic test_backpressure();
    logic [39:0] gv; logic [3:0] gd; logic gs; int lat, errs;
    do_txn(40'h0e2b994600, 4'd2, 5, gv, gd, gs, lat, errs);
    n_tests++; if (gv !== 40'h000e2b9946) begin n_fail++; $display("FAIL bp_val got=%h exp=000e2b9946", gv); end
    n_tests++; if (gd !== 4'd2) begin n_fail++; $display("FAIL bp_div got=%0d exp=2", gd); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL bp_latency got=%0d exp=3", lat); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL bp_hold_stable errors got=%0d exp=0", errs); end
  endtask

  task automatic test_saturate();
    logic [39:0] gv; logic [3:0] gd; logic gs; int lat, errs;
    do_txn(40'hffffffffff, 4'd15, 1, gv, gd, gs, lat, errs);
    n_tests++; if (gv !== 40'd0) begin n_fail++; $display("FAIL sat_val got=%h exp=0", gv); end
    n_tests++; if (gs !== 1'b1) begin n_fail++; $display("FAIL sat_flag got=%b exp=1", gs); end
    n_tests++; if (gd !== 4'd15) begin n_fail++; $display("FAIL sat_div got=%0d exp=15", gd); end
    n_tests++; if (lat != 11) begin n_fail++; $display("FAIL sat_latency got=%0d exp=11", lat); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL sat_handshake errors got=%0d exp=0", errs); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] gv; logic [3:0] gd; logic gs; int lat, errs;
    @(negedge clk);
    bus.in_val = 40'h123456789a; bus.in_divider = 4'd5; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    n_tests++; if (bus.out_val !== 40'd0) begin n_fail++; $display("FAIL rstmid_out_val got=%h exp=0", bus.out_val); end
    do_txn(40'h00154165e9, 4'd1, 0, gv, gd, gs, lat, errs);
    n_tests++; if (gv !== 40'h000154165e) begin n_fail++; $display("FAIL rstmid_fresh_val got=%h exp=000154165e", gv); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL rstmid_fresh_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] va, vb;
    int guard;
    va = {8'($urandom), 32'($urandom)};
    vb = {8'($urandom), 32'($urandom)};
    @(negedge clk);
    bus.in_val = va; bus.in_divider = 4'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_val = vb; bus.in_divider = 4'd1;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    n_tests++; if (bus.out_val !== model_val(va, 2)) begin n_fail++; $display("FAIL b2b_first_val got=%h exp=%h", bus.out_val, model_val(va, 2)); end
    n_tests++; if (bus.out_divider !== 4'd2) begin n_fail++; $display("FAIL b2b_first_div got=%0d exp=2", bus.out_divider); end
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap in_ready=%b out_valid=%b exp=1/0", bus.in_ready, bus.out_valid); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept busy=%b in_ready=%b exp=1/0", bus.busy, bus.in_ready); end
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    n_tests++; if (bus.out_val !== model_val(vb, 1)) begin n_fail++; $display("FAIL b2b_second_val got=%h exp=%h", bus.out_val, model_val(vb, 1)); end
    n_tests++; if (bus.out_divider !== 4'd1) begin n_fail++; $display("FAIL b2b_second_div got=%0d exp=1", bus.out_divider); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [39:0] v, gv; logic [3:0] d, gd; logic gs; int lat, errs, hold;
    for (int i = 0; i < 25; i++) begin
      v    = {8'($urandom), 32'($urandom)};
      d    = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      do_txn(v, d, hold, gv, gd, gs, lat, errs);
      n_tests++; if (gv !== model_val(v, int'(d))) begin n_fail++; $display("FAIL rand_val[%0d] got=%h exp=%h", i, gv, model_val(v, int'(d))); end
      n_tests++; if (gd !== d || gs !== (d > 4'd10)) begin n_fail++; $display("FAIL rand_div_sat[%0d] got=%0d/%b exp=%0d/%b", i, gd, gs, d, d > 4'd10); end
      n_tests++; if (lat != model_lat(int'(d))) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, model_lat(int'(d))); end
      n_tests++; if (errs != 0) begin n_fail++; $display("FAIL rand_handshake[%0d] errors got=%0d exp=0", i, errs); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_val = '0; bus.in_divider = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_shift();
    test_zero_div();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
